// File: rtl/image_pkg.sv
// Shared constants, FSM state type and row-address wrap helper for the image row streamer.
package image_pkg;

  localparam int unsigned ROW_W       = 3072;
  localparam int unsigned PIX_W       = 24;
  localparam int unsigned PIX_PER_ROW = ROW_W / PIX_W;
  localparam int unsigned ADDR_W      = 7;
  localparam int unsigned DEPTH       = 64;
  localparam int unsigned IDX_W       = $clog2(PIX_PER_ROW);
  localparam int unsigned OFF_W       = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STREAM, DONE} stream_state_t;

  // Bank row address of the row at offset `off` from `base`, wrapping modulo DEPTH.
  function automatic logic [ADDR_W-1:0] row_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [OFF_W-1:0]  off);
    return ADDR_W'((32'(base) + 32'(off)) % DEPTH);
  endfunction

endpackage

// File: rtl/image_row_streamer_row_serializer.sv
// Row serializer: holds one bank row and shifts it out one pixel per advance, lowest pixel first.
module row_serializer
  import image_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic             row_last,
  input  logic [ROW_W-1:0] row,
  output logic [PIX_W-1:0] pix,
  output logic             last,
  output logic             eof
);

  logic [ROW_W-1:0] shift_q;
  logic [IDX_W-1:0] idx_q;
  logic             row_last_q;
  logic             last_q;
  logic             eof_q;
  logic             next_last_c;

  // The pixel about to be exposed after this advance is the final one of the row.
  assign next_last_c = (idx_q == IDX_W'(PIX_PER_ROW - 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= '0;
      idx_q      <= '0;
      row_last_q <= 1'b0;
      last_q     <= 1'b0;
      eof_q      <= 1'b0;
    end else if (load) begin
      shift_q    <= row;
      idx_q      <= '0;
      row_last_q <= row_last;
      last_q     <= 1'b0;
      eof_q      <= 1'b0;
    end else if (advance) begin
      shift_q    <= shift_q >> PIX_W;
      idx_q      <= idx_q + IDX_W'(1);
      last_q     <= next_last_c;
      eof_q      <= next_last_c & row_last_q;
    end
  end

  assign pix  = shift_q[PIX_W-1:0];
  assign last = last_q;
  assign eof  = eof_q;

endmodule

// File: rtl/image_row_streamer.sv
// Streams bank rows base..base+n-1 (mod DEPTH) as a valid/ready pixel stream.
// Define IMG_STREAM_PREFETCH_EN to prefetch the next row and remove inter-row bubbles.
module image_row_streamer
  import image_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_row,
  input  logic [ADDR_W-1:0] num_rows,
  output logic              busy,
  output logic              done,
  output logic              bank_re,
  output logic [ADDR_W-1:0] bank_raddr,
  input  logic [ROW_W-1:0]  bank_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_eol,
  output logic              pix_eof
);

  stream_state_t     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] num_q, num_d;
  logic [ADDR_W-1:0] row_cnt_q, row_cnt_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              bank_re_q, bank_re_d;
  logic              busy_q, done_q, valid_q;

  logic ser_load, ser_advance, ser_row_last, ser_last;
  logic hs_c, last_row_c;

  assign hs_c       = valid_q & pix_ready;
  assign last_row_c = (row_cnt_q == num_q - ADDR_W'(1));

`ifdef IMG_STREAM_PREFETCH_EN
  logic next_last_row_c;
  assign next_last_row_c = (row_cnt_q + ADDR_W'(2) == num_q);
`endif

  // Next-state, counters and bank request for the following cycle.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    num_d        = num_q;
    row_cnt_d    = row_cnt_q;
    raddr_d      = raddr_q;
    bank_re_d    = 1'b0;
    ser_load     = 1'b0;
    ser_advance  = 1'b0;
    ser_row_last = last_row_c;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = ADDR_W'(32'(base_row) % DEPTH);
          num_d     = num_rows;
          row_cnt_d = '0;
          if (num_rows != '0) begin
            state_d   = ISSUE;
            bank_re_d = 1'b1;
            raddr_d   = row_addr(base_d, '0);
          end else begin
            state_d   = DONE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        ser_load = 1'b1;
        state_d  = STREAM;
`ifdef IMG_STREAM_PREFETCH_EN
        if (!last_row_c) begin
          bank_re_d = 1'b1;
          raddr_d   = row_addr(base_q, OFF_W'(row_cnt_q) + OFF_W'(1));
        end
`endif
      end
      STREAM: begin
        if (hs_c) begin
          ser_advance = 1'b1;
          if (ser_last) begin
            row_cnt_d = row_cnt_q + ADDR_W'(1);
            if (last_row_c) begin
              state_d = DONE;
            end else begin
`ifdef IMG_STREAM_PREFETCH_EN
              // Next row already sits on bank_rdata; swap it in without leaving STREAM.
              ser_load     = 1'b1;
              ser_row_last = next_last_row_c;
              if (!next_last_row_c) begin
                bank_re_d = 1'b1;
                raddr_d   = row_addr(base_q, OFF_W'(row_cnt_q) + OFF_W'(2));
              end
`else
              state_d   = ISSUE;
              bank_re_d = 1'b1;
              raddr_d   = row_addr(base_q, OFF_W'(row_cnt_d));
`endif
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      num_q     <= '0;
      row_cnt_q <= '0;
      raddr_q   <= '0;
      bank_re_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      num_q     <= num_d;
      row_cnt_q <= row_cnt_d;
      raddr_q   <= raddr_d;
      bank_re_q <= bank_re_d;
      busy_q    <= (state_d == ISSUE) || (state_d == WAIT) || (state_d == STREAM);
      done_q    <= (state_d == DONE);
      valid_q   <= (state_d == STREAM);
    end
  end

  row_serializer u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .advance  (ser_advance),
    .row_last (ser_row_last),
    .row      (bank_rdata),
    .pix      (pix_data),
    .last     (ser_last),
    .eof      (pix_eof)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign bank_re    = bank_re_q;
  assign bank_raddr = raddr_q;
  assign pix_valid  = valid_q;
  assign pix_eol    = ser_last;

endmodule

// File: tb/tb_image_row_streamer.sv
// Self-checking bench for image_row_streamer: table of streaming jobs plus a mid-job reset sequence.
module tb_image_row_streamer;
  import image_pkg::*;

`ifdef IMG_STREAM_PREFETCH_EN
  localparam int ROW_GAP = 0;
`else
  localparam int ROW_GAP = 2;
`endif
  localparam int PPR = int'(PIX_PER_ROW);
  localparam int DEP = int'(DEPTH);

  typedef struct {
    int base;
    int num;
    int mode;     // 0: ready always 1, 1: random 50%, 2: alternating
    int exp_re;
    int exp_pix;
    int exp_eol;
    int exp_eof;
    int exp_gap;  // idle valid cycles inside the job, -1 = not checked
  } job_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_row = '0;
  logic [ADDR_W-1:0] num_rows = '0;
  logic              busy, done, bank_re;
  logic [ADDR_W-1:0] bank_raddr;
  logic [ROW_W-1:0]  bank_rdata = '0;
  logic              pix_valid;
  logic              pix_ready = 1'b0;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_eol, pix_eof;

  logic [ROW_W-1:0]  mem [DEPTH];
  int checks = 0;
  int errors = 0;

  image_row_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_row   (base_row),
    .num_rows   (num_rows),
    .busy       (busy),
    .done       (done),
    .bank_re    (bank_re),
    .bank_raddr (bank_raddr),
    .bank_rdata (bank_rdata),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_eol    (pix_eol),
    .pix_eof    (pix_eof)
  );

  always #5 clk = ~clk;

  // Bank read port: one-cycle latency, data held while bank_re is low.
  always @(posedge clk) begin
    if (bank_re) bank_rdata <= mem[int'(bank_raddr) % DEP];
  end

  function automatic logic [PIX_W-1:0] pix_val(input int r, input int i);
    return {8'(r), 8'(i) ^ 8'h5A, 8'(i)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic jcheck(input int id, input string what, input int act, input int exp);
    check($sformatf("job%0d_%s", id, what), act, exp);
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_busy"},       int'(busy),       0);
    check({tag, "_done"},       int'(done),       0);
    check({tag, "_bank_re"},    int'(bank_re),    0);
    check({tag, "_bank_raddr"}, int'(bank_raddr), 0);
    check({tag, "_pix_valid"},  int'(pix_valid),  0);
    check({tag, "_pix_data"},   int'(pix_data),   0);
    check({tag, "_pix_eol"},    int'(pix_eol),    0);
    check({tag, "_pix_eof"},    int'(pix_eof),    0);
  endtask

  // Runs one job from the cycle start is driven (n=0); entered and left at #1 after a clock edge.
  task automatic run_job(input int id, input job_t j);
    int k = 0, re_cnt = 0, addr_err = 0, data_err = 0, eol_cnt = 0, eof_cnt = 0;
    int first_n = -1, last_hs_n = -1, done_n = -1, done_cnt = 0;
    int busy_err = 0, gap = 0, drop_err = 0;
    int r, i, brow;
    int base_m = j.base % DEP;
    int bnd = j.exp_pix * 4 + 200;
    logic busy_exp;
    base_row = ADDR_W'(j.base);
    num_rows = ADDR_W'(j.num);
    start    = 1'b1;
    for (int n = 0; n < bnd; n++) begin
      if (n == 1 || n == 11) start = 1'b0;
      if (n == 10 && j.num != 0) begin
        start    = 1'b1;
        base_row = '0;
        num_rows = ADDR_W'(1);
      end
      case (j.mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = 1'($urandom_range(0, 1));
        default: pix_ready = 1'(n % 2 == 0);
      endcase
      if (done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      busy_exp = (j.num != 0) && (n >= 1) && (done_n < 0);
      if (busy !== busy_exp) busy_err++;
      if (bank_re) begin
        if (int'(bank_raddr) != (base_m + re_cnt) % DEP) addr_err++;
        re_cnt++;
      end
      if (pix_valid) begin
        if (first_n < 0) first_n = n;
        r    = k / PPR;
        i    = k % PPR;
        brow = (base_m + r) % DEP;
        if (k >= j.exp_pix || pix_data !== pix_val(brow, i) ||
            pix_eol !== 1'(i == PPR - 1) || pix_eof !== 1'(k == j.exp_pix - 1))
          data_err++;
        if (pix_ready) begin
          eol_cnt  += int'(pix_eol);
          eof_cnt  += int'(pix_eof);
          k++;
          last_hs_n = n;
        end
      end else if (first_n >= 0 && k < j.exp_pix) begin
        if (k % PPR != 0) drop_err++;
        else gap++;
      end
      if (done_n >= 0 && n >= done_n + 2) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    jcheck(id, "done_seen",    (done_n >= 0) ? 1 : 0, 1);
    jcheck(id, "done_count",   done_cnt, 1);
    jcheck(id, "done_latency", done_n, (j.num == 0) ? 1 : last_hs_n + 1);
    jcheck(id, "bank_re_count", re_cnt, j.exp_re);
    jcheck(id, "raddr_errors", addr_err, 0);
    jcheck(id, "pixel_count",  k, j.exp_pix);
    jcheck(id, "pixel_errors", data_err, 0);
    jcheck(id, "eol_count",    eol_cnt, j.exp_eol);
    jcheck(id, "eof_count",    eof_cnt, j.exp_eof);
    jcheck(id, "busy_errors",  busy_err, 0);
    jcheck(id, "midrow_drops", drop_err, 0);
    jcheck(id, "first_valid",  first_n, (j.num != 0) ? 3 : -1);
    if (j.exp_gap >= 0) jcheck(id, "row_gap_cycles", gap, j.exp_gap);
  endtask

  initial begin
    job_t jobs[7];
    job_t after_rst;
    logic [ROW_W-1:0] row_tmp;
    int k;
    int hit;
    int quiet;

    for (int r = 0; r < DEP; r++) begin
      for (int i = 0; i < PPR; i++) row_tmp[i*PIX_W +: PIX_W] = pix_val(r, i);
      mem[r] = row_tmp;
    end

    jobs[0] = '{5,   1, 0, 1,  128,  1,  1, 0};
    jobs[1] = '{62,  4, 0, 4,  512,  4,  1, 3 * ROW_GAP};
    jobs[2] = '{20,  3, 1, 3,  384,  3,  1, -1};
    jobs[3] = '{0,   0, 0, 0,  0,    0,  0, 0};
    jobs[4] = '{7,   3, 0, 3,  384,  3,  1, 2 * ROW_GAP};
    jobs[5] = '{100, 2, 2, 2,  256,  2,  1, -1};
    jobs[6] = '{0,  64, 0, 64, 8192, 64, 1, 63 * ROW_GAP};
    after_rst = '{3, 2, 0, 2, 256, 2, 1, ROW_GAP};

    repeat (3) @(posedge clk);
    #1;
    check_quiet_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 7; t++) run_job(t, jobs[t]);

    // Abort at pixel 60 of row 2 of a 4-row job starting at row 10.
    base_row  = ADDR_W'(10);
    num_rows  = ADDR_W'(4);
    pix_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k   = 0;
    hit = 0;
    for (int n = 0; n < 2000; n++) begin
      if (pix_valid) begin
        if (k == 2 * PPR + 60) begin
          hit = 1;
          break;
        end
        if (pix_ready) k++;
      end
      @(posedge clk); #1;
    end
    check("abort_reached_pixel", hit, 1);
    check("abort_pixel_data", int'(pix_data), int'(pix_val(12, 60)));
    rst = 1'b1;
    @(posedge clk); #1;
    check_quiet_outputs("abort");
    rst   = 1'b0;
    quiet = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      quiet += int'(done) + int'(pix_valid) + int'(bank_re) + int'(busy);
    end
    check("abort_no_activity", quiet, 0);

    run_job(7, after_rst);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
